// File: rtl/mips_lsu_if.sv
// Core-side request/response and data-memory bus bundle for mips_lsu.
// slave = the load/store unit, master = core plus memory environment.
interface mips_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt_old;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        data_waitrequest;

    modport slave (
        input  req_valid, req_write, req_op, req_addr, req_wdata, req_rt_old,
        input  data_readdata, data_waitrequest,
        output req_ready, resp_valid, resp_rdata, resp_error, busy,
        output data_address, data_read, data_write, data_byteenable, data_writedata
    );

    modport master (
        output req_valid, req_write, req_op, req_addr, req_wdata, req_rt_old,
        output data_readdata, data_waitrequest,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy,
        input  data_address, data_read, data_write, data_byteenable, data_writedata
    );
endinterface

// File: rtl/mips_lsu.sv
// MIPS load/store unit: lane alignment, byte enables, load extension, wait/timeout bus FSM.
// Define MIPS_LSU_LWLR_EN to support LWL/LWR; otherwise ops 010/110 are rejected.
module mips_lsu #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clk_enable,
    mips_lsu_if.slave  io_lsu
);
    localparam logic [15:0] TimeoutLast = 16'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t      r_state;
    logic        r_write;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic [15:0] r_cnt;
    logic        r_data_read;
    logic        r_data_write;
    logic [31:0] r_address;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_error;
    logic [31:0] r_resp_rdata;

    logic        w_req_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_timeout;

`ifdef MIPS_LSU_LWLR_EN
    logic [31:0] r_rt_old;
`else
    logic        w_unused_rt_old;
    assign w_unused_rt_old = ^io_lsu.req_rt_old;
`endif

    always_comb begin
        w_req_err = 1'b0;
        case (io_lsu.req_op)
            3'b111:         w_req_err = 1'b1;
            3'b001, 3'b101: w_req_err = io_lsu.req_addr[0];
            3'b011:         w_req_err = (io_lsu.req_addr[1:0] != 2'b00);
`ifndef MIPS_LSU_LWLR_EN
            3'b010, 3'b110: w_req_err = 1'b1;
`endif
            default:        w_req_err = 1'b0;
        endcase
        if (io_lsu.req_write && !(io_lsu.req_op inside {3'b000, 3'b001, 3'b011})) begin
            w_req_err = 1'b1;
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'h0;
        if (io_lsu.req_write) begin
            case (io_lsu.req_op)
                3'b000: begin
                    w_be    = 4'b0001 << io_lsu.req_addr[1:0];
                    w_wdata = {4{io_lsu.req_wdata[7:0]}};
                end
                3'b001: begin
                    w_be    = io_lsu.req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{io_lsu.req_wdata[15:0]}};
                end
                default: w_wdata = io_lsu.req_wdata;
            endcase
        end
    end

    // Formatting uses the latched op/offset against the live read data.
    always_comb begin
        w_byte = 8'(io_lsu.data_readdata >> {r_addr_lo, 3'b000});
        w_half = r_addr_lo[1] ? io_lsu.data_readdata[31:16] : io_lsu.data_readdata[15:0];
        w_load = io_lsu.data_readdata;
        case (r_op)
            3'b000: w_load = {{24{w_byte[7]}}, w_byte};
            3'b100: w_load = {24'h0, w_byte};
            3'b001: w_load = {{16{w_half[15]}}, w_half};
            3'b101: w_load = {16'h0, w_half};
`ifdef MIPS_LSU_LWLR_EN
            3'b010: w_load = (io_lsu.data_readdata << {~r_addr_lo, 3'b000})
                           | (r_rt_old & ((32'h1 << {~r_addr_lo, 3'b000}) - 32'h1));
            3'b110: w_load = (io_lsu.data_readdata >> {r_addr_lo, 3'b000})
                           | (r_rt_old & ~(32'hFFFF_FFFF >> {r_addr_lo, 3'b000}));
`endif
            default: w_load = io_lsu.data_readdata;
        endcase
    end

    // Timeout takes priority over a completion on the same edge.
    assign w_timeout = io_lsu.data_waitrequest && (r_cnt == TimeoutLast);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_write      <= 1'b0;
            r_op         <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_cnt        <= 16'h0;
            r_data_read  <= 1'b0;
            r_data_write <= 1'b0;
            r_address    <= 32'h0;
            r_be         <= 4'h0;
            r_wdata      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= 32'h0;
`ifdef MIPS_LSU_LWLR_EN
            r_rt_old     <= 32'h0;
`endif
        end else if (i_clk_enable) begin
            case (r_state)
                StIdle: begin
                    r_resp_valid <= 1'b0;
                    r_resp_error <= 1'b0;
                    r_resp_rdata <= 32'h0;
                    if (io_lsu.req_valid) begin
                        r_write   <= io_lsu.req_write;
                        r_op      <= io_lsu.req_op;
                        r_addr_lo <= io_lsu.req_addr[1:0];
`ifdef MIPS_LSU_LWLR_EN
                        r_rt_old  <= io_lsu.req_rt_old;
`endif
                        if (w_req_err) begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else begin
                            r_state      <= StAccess;
                            r_cnt        <= 16'h0;
                            r_data_read  <= !io_lsu.req_write;
                            r_data_write <= io_lsu.req_write;
                            r_address    <= {io_lsu.req_addr[31:2], 2'b00};
                            r_be         <= w_be;
                            r_wdata      <= w_wdata;
                        end
                    end
                end
                StAccess: begin
                    if (w_timeout || !io_lsu.data_waitrequest) begin
                        r_state      <= StResp;
                        r_cnt        <= 16'h0;
                        r_data_read  <= 1'b0;
                        r_data_write <= 1'b0;
                        r_address    <= 32'h0;
                        r_be         <= 4'h0;
                        r_wdata      <= 32'h0;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= w_timeout;
                        r_resp_rdata <= (w_timeout || r_write) ? 32'h0 : w_load;
                    end else begin
                        r_cnt <= r_cnt + 16'h1;
                    end
                end
                StResp: begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b0;
                    r_resp_error <= 1'b0;
                    r_resp_rdata <= 32'h0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_lsu.req_ready       = (r_state == StIdle);
    assign io_lsu.busy            = (r_state != StIdle);
    assign io_lsu.resp_valid      = r_resp_valid;
    assign io_lsu.resp_error      = r_resp_error;
    assign io_lsu.resp_rdata      = r_resp_rdata;
    assign io_lsu.data_address    = r_address;
    assign io_lsu.data_read       = r_data_read;
    assign io_lsu.data_write      = r_data_write;
    assign io_lsu.data_byteenable = r_be;
    assign io_lsu.data_writedata  = r_wdata;
endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu (WAIT_TIMEOUT=4): expected responses and bus beats are
// queued at issue time and checked by independent monitors.
module tb_mips_lsu;
    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    mips_lsu_if lsu ();

    mips_lsu #(.WAIT_TIMEOUT(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_clk_enable (clk_en),
        .io_lsu       (lsu)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    int          wait_n = 0;
    int          wcnt = 0;
    logic [31:0] mem_word = 32'h0;
    logic        prev_strobe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: holds waitrequest for wait_n enabled cycles of each access.
    assign lsu.data_readdata = mem_word;
    always @(negedge clk) begin
        if (lsu.data_read || lsu.data_write) lsu.data_waitrequest = (wcnt < wait_n);
        else lsu.data_waitrequest = 1'b0;
    end
    always @(posedge clk) begin
        if (!(lsu.data_read || lsu.data_write)) wcnt = 0;
        else if (clk_en && lsu.data_waitrequest) wcnt = wcnt + 1;
    end

    always @(negedge clk) begin
        resp_t r;
        if (rst_n && lsu.resp_valid) begin
            if (resp_q.size() == 0) begin
                check("resp_unexpected", 32'(lsu.resp_valid), 32'h0);
            end else begin
                r = resp_q.pop_front();
                check("resp_rdata", lsu.resp_rdata, r.rdata);
                check("resp_error", 32'(lsu.resp_error), 32'(r.err));
                check("resp_cycle", 32'(cyc), 32'(r.at));
            end
        end
    end

    always @(negedge clk) begin
        bus_t b;
        if (lsu.data_read && lsu.data_write) check("strobe_excl", 32'h1, 32'h0);
        if (lsu.data_read || lsu.data_write) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 32'(lsu.data_read || lsu.data_write), 32'h0);
            end else begin
                b = bus_q[0];
                check("bus_write", 32'(lsu.data_write), 32'(b.wr));
                check("bus_addr", lsu.data_address, b.addr);
                check("bus_be", 32'(lsu.data_byteenable), 32'(b.be));
                if (b.wr) check("bus_wdata", lsu.data_writedata, b.wd);
            end
        end else if (prev_strobe && bus_q.size() > 0) begin
            void'(bus_q.pop_front());
        end
        prev_strobe = lsu.data_read || lsu.data_write;
    end

    task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rt,
                         input logic [31:0] mem, input int waits, input logic exp_resp,
                         input logic exp_err, input logic [31:0] exp_rdata, input int edges,
                         input logic bus, input logic [3:0] be, input logic [31:0] wd);
        int    guard;
        resp_t r;
        bus_t  b;
        guard = 0;
        while (!lsu.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!lsu.req_ready) check("ready_timeout", 32'(lsu.req_ready), 32'h1);
        mem_word = mem;
        wait_n   = waits;
        if (exp_resp) begin
            r.rdata = exp_rdata;
            r.err   = exp_err;
            r.at    = cyc + 1 + edges;
            resp_q.push_back(r);
        end
        if (bus) begin
            b.wr   = wr;
            b.addr = {addr[31:2], 2'b00};
            b.be   = be;
            b.wd   = wd;
            bus_q.push_back(b);
        end
        lsu.req_valid  = 1'b1;
        lsu.req_write  = wr;
        lsu.req_op     = op;
        lsu.req_addr   = addr;
        lsu.req_wdata  = wdata;
        lsu.req_rt_old = rt;
        @(negedge clk);
        lsu.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        lwlr_err;
        logic [31:0] lwl_exp;
        logic [31:0] lwr_exp;
        int          guard;
`ifdef MIPS_LSU_LWLR_EN
        lwlr_err = 1'b0;
        lwl_exp  = 32'hCCDD_3344;
        lwr_exp  = 32'h11AA_BBCC;
`else
        lwlr_err = 1'b1;
        lwl_exp  = 32'h0;
        lwr_exp  = 32'h0;
`endif
        rst_n = 1'b0;
        clk_en = 1'b1;
        lsu.req_valid = 1'b0;
        lsu.req_write = 1'b0;
        lsu.req_op = 3'b000;
        lsu.req_addr = 32'h0;
        lsu.req_wdata = 32'h0;
        lsu.req_rt_old = 32'h0;
        lsu.data_waitrequest = 1'b0;
        #1;
        check("rst_req_ready", 32'(lsu.req_ready), 32'h1);
        check("rst_busy", 32'(lsu.busy), 32'h0);
        check("rst_resp_valid", 32'(lsu.resp_valid), 32'h0);
        check("rst_strobes", 32'({lsu.data_read, lsu.data_write}), 32'h0);
        check("rst_be", 32'(lsu.data_byteenable), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //    wr    op      addr          wdata         rt            mem        wt rsp err rdata edges bus be  wd
        issue(1'b0, 3'b000, 32'h1003, 32'h0, 32'h0, 32'h80FF_1234, 0, 1, 0, 32'hFFFF_FF80, 1, 1, 4'hF, 0);
        issue(1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1, 4'hC, 32'hBEEF_BEEF);
        issue(1'b0, 3'b011, 32'h3001, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h0, 0, 0, 4'h0, 0);
        issue(1'b0, 3'b101, 32'h4000, 32'h0, 32'h0, 32'h1234_8001, 3, 1, 0, 32'h0000_8001, 4, 1, 4'hF, 0);
        issue(1'b0, 3'b011, 32'h4004, 32'h0, 32'h0, 32'h5555_5555, 4, 1, 1, 32'h0, 4, 1, 4'hF, 0);
        issue(1'b0, 3'b010, 32'h5001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, lwlr_err, lwl_exp,
              lwlr_err ? 0 : 1, !lwlr_err, 4'hF, 0);
        issue(1'b0, 3'b110, 32'h5001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, lwlr_err, lwr_exp,
              lwlr_err ? 0 : 1, !lwlr_err, 4'hF, 0);
        issue(1'b1, 3'b000, 32'h6001, 32'h1234_5678, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1, 4'h2, 32'h7878_7878);
        issue(1'b1, 3'b011, 32'h7000, 32'hDEAD_BEEF, 0, 32'h0, 1, 1, 0, 32'h0, 2, 1, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 3'b001, 32'h8002, 32'h0, 32'h0, 32'h8001_7FFF, 0, 1, 0, 32'hFFFF_8001, 1, 1, 4'hF, 0);
        issue(1'b0, 3'b100, 32'h9002, 32'h0, 32'h0, 32'h00A5_0000, 0, 1, 0, 32'h0000_00A5, 1, 1, 4'hF, 0);
        issue(1'b1, 3'b100, 32'h9000, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h0, 0, 0, 4'h0, 0);
        issue(1'b0, 3'b111, 32'h9000, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h0, 0, 0, 4'h0, 0);
        issue(1'b1, 3'b001, 32'h2001, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h0, 0, 0, 4'h0, 0);

        // Five disabled cycles inside a 3-wait access: must not count toward the timeout.
        issue(1'b0, 3'b101, 32'hA002, 32'h0, 32'h0, 32'hBEEF_0000, 3, 1, 0, 32'h0000_BEEF, 9, 1, 4'hF, 0);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_read", 32'(lsu.data_read), 32'h1);
        check("hold_busy", 32'(lsu.busy), 32'h1);
        clk_en = 1'b1;

        // Reset during a long wait abandons the access with no response.
        issue(1'b0, 3'b011, 32'hB000, 32'h0, 32'h0, 32'h0, 10, 0, 0, 32'h0, 0, 1, 4'hF, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_read", 32'(lsu.data_read), 32'h0);
        check("midrst_ready", 32'(lsu.req_ready), 32'h1);
        check("midrst_busy", 32'(lsu.busy), 32'h0);
        check("midrst_addr", lsu.data_address, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b1, 3'b011, 32'hC004, 32'h0BAD_F00D, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1, 4'hF, 32'h0BAD_F00D);

        guard = 0;
        while ((resp_q.size() != 0 || lsu.busy) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("resp_drain", 32'(resp_q.size()), 32'h0);
        check("bus_drain", 32'(bus_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit sitting directly downstream of the Harvard MIPS CPU core's memory stage: it accepts one decoded load/store request per transaction and performs the byte-lane alignment, byte enables and sign/zero extension. It drives the data-memory bus with a wait-request handshake and returns either the formatted load result or an error to the core. The core stalls while `busy` is high.

## Interface
- `WAIT_TIMEOUT`, default 255: max consecutive `data_waitrequest` cycles before the access aborts with error; legal range 1..65535.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clk_enable`  in  1  when low, all state (FSM, registers, timeout counter) holds.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high in IDLE only.
- `req_write`  in  1  opcode bit 29; 1 = store.
- `req_op`  in  3  opcode bits 28:26: 000 B, 001 H, 010 WL, 011 W, 100 BU, 101 HU, 110 WR, 111 illegal.
- `req_addr`  in  32  effective byte address.
- `req_wdata`  in  32  store data (rt).
- `req_rt_old`  in  32  current rt, merged for LWL/LWR.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  formatted load result; 0 for stores and errors.
- `resp_error`  out  1  valid with `resp_valid`; misaligned, illegal or timeout.
- `busy`  out  1  high in ACCESS and RESP.
- `data_address`  out  32  word address, `{req_addr[31:2],2'b00}`.
- `data_read` / `data_write`  out  1 each  bus strobes, mutually exclusive.
- `data_byteenable`  out  4  lane k = bits 8k+7:8k, little-endian.
- `data_writedata`  out  32  lane-replicated store data.
- `data_readdata`  in  32  read data, valid when `data_waitrequest` low.
- `data_waitrequest`  in  1  slave stall.

## Operation
- FSM: IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on error detection.
- IDLE: on `req_valid && clk_enable`, latch request. Error if: op 111; store op not in {000,001,011}; H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0; LWL/LWR without macro. Error -> RESP, no bus strobe.
- ACCESS: strobes, address, byteenable, writedata held stable. Completion when `data_waitrequest` low; timeout counter increments each waited cycle; reaching `WAIT_TIMEOUT` drops strobes, goes RESP with error.
- Store formatting, o = addr[1:0]: SB writedata `{4{wdata[7:0]}}`, BE `0001<<o`; SH `{2{wdata[15:0]}}`, BE `0011<<(2*addr[1])`; SW wdata, BE 1111.
- Load: B/BU select lane o, sign/zero-extend; H/HU select half addr[1]; W whole word; loads drive BE 1111.
- LWL: result = (mem << 8*(3-o)) | (rt_old & ((1<<8*(3-o))-1)). LWR: result = (mem >> 8*o) | (rt_old & ~(32'hFFFFFFFF >> 8*o)).
- RESP: `resp_valid`=1 one cycle, then IDLE.

## Timing
- Reset (async, low): FSM IDLE, all outputs 0 except `req_ready`=1; counter 0. Reset mid-ACCESS abandons access immediately, strobes drop asynchronously.
- Bus outputs registered. Request accepted edge T; strobes visible T..T+1; zero-wait completes at edge T+1; `resp_valid` high during cycle T+1..T+2. Min latency 2 cycles, +1 per wait cycle.
- Error path: `resp_valid` in the cycle after acceptance.
- `req_ready` low in ACCESS/RESP; back-to-back requests: next accepted the cycle after RESP (3-cycle throughput).
- `clk_enable` low: no state change; strobes remain asserted if in ACCESS; waits not counted.
- Timeout with `WAIT_TIMEOUT`=N: abort after N consecutive waitrequest-high cycles, even if waitrequest drops on the same edge (timeout wins).

## Configuration
- `MIPS_LSU_LWLR_EN` defined: LWL/LWR (op 010/110, loads) supported per formulas; misalignment ignored for them.
- Undefined: op 010/110 flagged as illegal -> `resp_error`, no bus access; merge logic not synthesised.

## Test plan
- LB addr 0x1003, mem 0x80FF_1234 -> byteenable 1111, `resp_rdata` 0xFFFF_FF80, 2-cycle latency.
- SH addr 0x2002, wdata 0x0000_BEEF -> writedata 0xBEEF_BEEF, byteenable 1100, `data_write` one cycle, `resp_rdata` 0.
- LW addr 0x3001 -> no strobe, `resp_error`=1 next cycle.
- LHU addr 0x4000, waitrequest high 3 cycles, mem 0x1234_8001 -> `resp_rdata` 0x0000_8001, latency 5; `WAIT_TIMEOUT`=4 with 4 wait cycles -> error, strobes drop.
- Macro on: LWL addr 0x5001, mem 0xAABB_CCDD, rt 0x1122_3344 -> 0xCCDD_3344; LWR same -> 0x11AA_BBCC. Macro off: error.
- Reset low mid-ACCESS, and `clk_enable` low during wait -> outputs 0/`req_ready`=1 immediately; counter frozen while disabled.
